// File: rtl/id_ex_stage.sv
//==============================================================================
// id_ex_stage : ID/EX pipeline register with operand forwarding and load-use
//               hazard bubble insertion in front of a 64-bit ALU.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RADDR-1:0] rs1_addr,
  input  logic [RADDR-1:0] rs2_addr,
  input  logic [RADDR-1:0] rd_addr,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  input  logic             alu_src_imm,
  input  logic             alu_src_pc,
  input  logic [3:0]       ALUOp_in,
  input  logic             reg_write_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             out_ready,
  input  logic             flush,
  input  logic             fwd_mem_we,
  input  logic [RADDR-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]  fwd_mem_data,
  input  logic             fwd_wb_we,
  input  logic [RADDR-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]  fwd_wb_data,
  output logic             out_valid,
  output logic [XLEN-1:0]  A,
  output logic [XLEN-1:0]  B,
  output logic [3:0]       ALUOp,
  output logic [XLEN-1:0]  store_data,
  output logic [RADDR-1:0] rd_out,
  output logic             reg_write_out,
  output logic             mem_read_out,
  output logic             mem_write_out
);

  logic             valid_q,       valid_d;
  logic [RADDR-1:0] rs1_addr_q,    rs1_addr_d;
  logic [RADDR-1:0] rs2_addr_q,    rs2_addr_d;
  logic [RADDR-1:0] rd_q,          rd_d;
  logic [XLEN-1:0]  rs1_val_q,     rs1_val_d;
  logic [XLEN-1:0]  rs2_val_q,     rs2_val_d;
  logic [XLEN-1:0]  imm_q,         imm_d;
  logic [XLEN-1:0]  pc_q,          pc_d;
  logic             src_imm_q,     src_imm_d;
  logic             src_pc_q,      src_pc_d;
  logic [3:0]       aluop_q,       aluop_d;
  logic             reg_write_q,   reg_write_d;
  logic             mem_read_q,    mem_read_d;
  logic             mem_write_q,   mem_write_d;

  logic             advance;
  logic             hazard;
  logic [XLEN-1:0]  rs1_cap;
  logic [XLEN-1:0]  rs2_cap;
  logic [XLEN-1:0]  fwd_rs1;
  logic [XLEN-1:0]  fwd_rs2;

  // Newest producer wins: MEM over WB over the captured value; x0 is never bypassed.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [RADDR-1:0] addr,
                                              input logic [XLEN-1:0]  held);
    if (addr == '0)                             return held;
    else if (fwd_mem_we && fwd_mem_rd == addr)  return fwd_mem_data;
    else if (fwd_wb_we && fwd_wb_rd == addr)    return fwd_wb_data;
    else                                        return held;
  endfunction

  always_comb begin
    advance  = !valid_q || out_ready;
    hazard   = valid_q && mem_read_q && (rd_q != '0) && in_valid &&
               ((uses_rs1 && rs1_addr == rd_q) || (uses_rs2 && rs2_addr == rd_q));
    in_ready = advance && !hazard && !flush;

    // The register file does not yet reflect the value WB writes this cycle.
    rs1_cap = (fwd_wb_we && fwd_wb_rd == rs1_addr && rs1_addr != '0) ? fwd_wb_data : rs1_data;
    rs2_cap = (fwd_wb_we && fwd_wb_rd == rs2_addr && rs2_addr != '0) ? fwd_wb_data : rs2_data;
  end

  always_comb begin
    valid_d     = valid_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_d        = rd_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    src_imm_d   = src_imm_q;
    src_pc_d    = src_pc_q;
    aluop_d     = aluop_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;

    if (flush || (advance && !(in_valid && !hazard))) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (advance) begin
      valid_d     = 1'b1;
      rs1_addr_d  = rs1_addr;
      rs2_addr_d  = rs2_addr;
      rd_d        = rd_addr;
      rs1_val_d   = rs1_cap;
      rs2_val_d   = rs2_cap;
      imm_d       = imm;
      pc_d        = pc;
      src_imm_d   = alu_src_imm;
      src_pc_d    = alu_src_pc;
      aluop_d     = ALUOp_in;
      reg_write_d = reg_write_in;
      mem_read_d  = mem_read_in;
      mem_write_d = mem_write_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      src_imm_q   <= 1'b0;
      src_pc_q    <= 1'b0;
      aluop_q     <= 4'b0000;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_q        <= rd_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      src_imm_q   <= src_imm_d;
      src_pc_q    <= src_pc_d;
      aluop_q     <= aluop_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  always_comb begin
    fwd_rs1       = fwd_sel(rs1_addr_q, rs1_val_q);
    fwd_rs2       = fwd_sel(rs2_addr_q, rs2_val_q);
    out_valid     = valid_q;
    A             = valid_q ? (src_pc_q  ? pc_q  : fwd_rs1) : '0;
    B             = valid_q ? (src_imm_q ? imm_q : fwd_rs2) : '0;
    store_data    = valid_q ? fwd_rs2 : '0;
    ALUOp         = valid_q ? aluop_q : 4'b0000;
    rd_out        = rd_q;
    reg_write_out = valid_q && reg_write_q;
    mem_read_out  = valid_q && mem_read_q;
    mem_write_out = valid_q && mem_write_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//==============================================================================
// tb_id_ex_stage : directed and randomized checks of id_ex_stage against a
//                  behavioural pipeline-register model.
// Revision       : 1.0
//==============================================================================
`default_nettype none

module tb_id_ex_stage;
  localparam int XLEN  = 64;
  localparam int RADDR = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [RADDR-1:0] rs1_addr, rs2_addr, rd_addr;
  logic             uses_rs1, uses_rs2;
  logic [XLEN-1:0]  rs1_data, rs2_data, imm, pc;
  logic             alu_src_imm, alu_src_pc;
  logic [3:0]       ALUOp_in;
  logic             reg_write_in, mem_read_in, mem_write_in;
  logic             out_ready, flush;
  logic             fwd_mem_we, fwd_wb_we;
  logic [RADDR-1:0] fwd_mem_rd, fwd_wb_rd;
  logic [XLEN-1:0]  fwd_mem_data, fwd_wb_data;
  logic             out_valid;
  logic [XLEN-1:0]  A, B, store_data;
  logic [3:0]       ALUOp;
  logic [RADDR-1:0] rd_out;
  logic             reg_write_out, mem_read_out, mem_write_out;

  int npass = 0;
  int ntotal = 0;

  id_ex_stage #(.XLEN(XLEN), .RADDR(RADDR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .alu_src_imm(alu_src_imm), .alu_src_pc(alu_src_pc), .ALUOp_in(ALUOp_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .out_ready(out_ready), .flush(flush),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .A(A), .B(B), .ALUOp(ALUOp), .store_data(store_data),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out)
  );

  always #5 clk = ~clk;

  // Model of the instruction currently held in the stage.
  typedef struct {
    bit             v;
    bit [RADDR-1:0] rs1, rs2, rd;
    bit [XLEN-1:0]  r1, r2, imm, pc;
    bit             simm, spc;
    bit [3:0]       op;
    bit             rw, mr, mw;
  } held_t;

  held_t m = '{default: '0};

  function automatic bit model_hazard();
    return m.v && m.mr && m.rd != 0 && in_valid &&
           ((uses_rs1 && rs1_addr == m.rd) || (uses_rs2 && rs2_addr == m.rd));
  endfunction

  function automatic bit [XLEN-1:0] newest(bit [RADDR-1:0] a, bit [XLEN-1:0] held);
    if (a == 0) return held;
    if (fwd_mem_we && fwd_mem_rd == a) return fwd_mem_data;
    if (fwd_wb_we && fwd_wb_rd == a) return fwd_wb_data;
    return held;
  endfunction

  function automatic bit [XLEN-1:0] wb_bypass(bit [RADDR-1:0] a, bit [XLEN-1:0] rf);
    return (fwd_wb_we && fwd_wb_rd == a && a != 0) ? fwd_wb_data : rf;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m = '{default: '0};
    end else begin
      bit adv, hz;
      adv = !m.v || out_ready;
      hz  = model_hazard();
      if (flush) begin
        m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0;
      end else if (adv && in_valid && !hz) begin
        m = '{v: 1, rs1: rs1_addr, rs2: rs2_addr, rd: rd_addr,
              r1: wb_bypass(rs1_addr, rs1_data), r2: wb_bypass(rs2_addr, rs2_data),
              imm: imm, pc: pc, simm: alu_src_imm, spc: alu_src_pc, op: ALUOp_in,
              rw: reg_write_in, mr: mem_read_in, mw: mem_write_in};
      end else if (adv) begin
        m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0;
      end
    end
  end

  task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    bit [XLEN-1:0] f1, f2;
    f1 = newest(m.rs1, m.r1);
    f2 = newest(m.rs2, m.r2);
    chk("m_out_valid", out_valid, m.v);
    chk("m_in_ready",  in_ready, (!m.v || out_ready) && !model_hazard() && !flush);
    chk("m_A",         A,          m.v ? (m.spc ? m.pc : f1) : 0);
    chk("m_B",         B,          m.v ? (m.simm ? m.imm : f2) : 0);
    chk("m_store",     store_data, m.v ? f2 : 0);
    chk("m_ALUOp",     ALUOp,      m.v ? m.op : 0);
    chk("m_rw",        reg_write_out, m.v & m.rw);
    chk("m_mr",        mem_read_out,  m.v & m.mr);
    chk("m_mw",        mem_write_out, m.v & m.mw);
    if (m.v) chk("m_rd", rd_out, m.rd);
  end

  task automatic set_idle();
    in_valid = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
    uses_rs1 = 0; uses_rs2 = 0; rs1_data = 0; rs2_data = 0; imm = 0; pc = 0;
    alu_src_imm = 0; alu_src_pc = 0; ALUOp_in = 0;
    reg_write_in = 0; mem_read_in = 0; mem_write_in = 0;
    out_ready = 1; flush = 0;
    fwd_mem_we = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
    fwd_wb_we = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
  endtask

  task automatic instr(bit [4:0] r1, bit [4:0] r2, bit [4:0] rd,
                       bit [63:0] d1, bit [63:0] d2, bit [3:0] op, bit mr);
    in_valid = 1; rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
    uses_rs1 = 1; uses_rs2 = 1; rs1_data = d1; rs2_data = d2;
    ALUOp_in = op; reg_write_in = 1; mem_read_in = mr; mem_write_in = 0;
    alu_src_imm = 0; alu_src_pc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    reset = 1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_A", A, 0);
    chk("rst_ALUOp", ALUOp, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 0;

    // Basic accept and one-cycle latency
    instr(1, 2, 3, 10, 10, 4'b0010, 0);
    sample(); chk("t1_in_ready", in_ready, 1);
    tick(); set_idle();
    sample();
    chk("t1_valid", out_valid, 1); chk("t1_A", A, 10); chk("t1_B", B, 10);
    chk("t1_op", ALUOp, 4'b0010); chk("t1_rd", rd_out, 3);
    tick();

    // Output forwarding priority
    instr(5, 6, 8, 111, 222, 4'b0011, 0);
    tick(); set_idle(); out_ready = 0;
    fwd_mem_we = 1; fwd_mem_rd = 5; fwd_mem_data = 30;
    fwd_wb_we = 1;  fwd_wb_rd = 5;  fwd_wb_data = 99;
    sample(); chk("t2_mem_wins", A, 30);
    tick(); fwd_mem_we = 0;
    sample(); chk("t2_wb", A, 99);
    tick();
    instr(0, 6, 8, 77, 222, 4'b0100, 0); out_ready = 1;
    fwd_wb_rd = 0;
    tick(); set_idle(); out_ready = 0;
    fwd_mem_we = 1; fwd_mem_rd = 0; fwd_mem_data = 30;
    fwd_wb_we = 1;  fwd_wb_rd = 0;  fwd_wb_data = 99;
    sample(); chk("t2_x0", A, 77);
    tick();

    // Downstream stall holds the instruction
    set_idle(); instr(1, 2, 9, 1, 2, 4'b0001, 0);
    tick(); set_idle(); out_ready = 0; instr(1, 2, 10, 3, 4, 4'b0101, 0);
    for (int i = 0; i < 3; i++) begin
      sample(); chk("t4_hold_op", ALUOp, 4'b0001); chk("t4_hold_rdy", in_ready, 0);
      tick();
    end
    out_ready = 1;
    sample(); chk("t4_release_rdy", in_ready, 1);
    tick(); in_valid = 0; out_ready = 0;
    sample(); chk("t4_next_op", ALUOp, 4'b0101);
    tick();

    // Flush beats a stalled held instruction
    instr(1, 2, 11, 5, 6, 4'b0110, 0); out_ready = 0; flush = 1;
    sample(); chk("t5_in_ready", in_ready, 0);
    tick(); set_idle();
    sample();
    chk("t5_valid", out_valid, 0); chk("t5_op", ALUOp, 0); chk("t5_rw", reg_write_out, 0);
    tick();

    // Load-use hazard
    instr(1, 2, 7, 0, 0, 4'b0000, 1);
    tick(); instr(1, 7, 12, 5, 64'hDEAD, 4'b0010, 0);
    sample(); chk("t3_hazard_rdy", in_ready, 0);
    tick(); fwd_mem_we = 1; fwd_mem_rd = 7; fwd_mem_data = 64'hABC;
    sample(); chk("t3_bubble", out_valid, 0); chk("t3_rdy_again", in_ready, 1);
    tick(); in_valid = 0;
    sample(); chk("t3_valid", out_valid, 1); chk("t3_B_fwd", B, 64'hABC);
    tick();

    // Capture bypass from WB
    set_idle(); instr(4, 2, 13, 0, 1, 4'b0111, 0);
    fwd_wb_we = 1; fwd_wb_rd = 4; fwd_wb_data = 64'h3FF;
    tick(); set_idle(); out_ready = 0;
    sample(); chk("t6_A", A, 64'h3FF);
    tick();
    sample(); chk("t6_A_persist", A, 64'h3FF);

    // Reset during a stall discards the held instruction
    #2 reset = 1;
    #1 chk("t7_async_valid", out_valid, 0); chk("t7_async_A", A, 0);
    tick(); reset = 0; instr(1, 2, 3, 4, 5, 4'b0001, 0); out_ready = 0;
    sample(); chk("t7_in_ready", in_ready, 1);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid     = ($urandom % 4) != 0;
      rs1_addr     = 5'($urandom % 8);
      rs2_addr     = 5'($urandom % 8);
      rd_addr      = 5'($urandom % 8);
      uses_rs1     = 1'($urandom);
      uses_rs2     = 1'($urandom);
      rs1_data     = {$urandom, $urandom};
      rs2_data     = {$urandom, $urandom};
      imm          = {$urandom, $urandom};
      pc           = {$urandom, $urandom};
      alu_src_imm  = 1'($urandom);
      alu_src_pc   = 1'($urandom);
      ALUOp_in     = 4'($urandom);
      reg_write_in = 1'($urandom);
      mem_read_in  = ($urandom % 3) == 0;
      mem_write_in = 1'($urandom);
      out_ready    = ($urandom % 4) != 0;
      flush        = ($urandom % 20) == 0;
      fwd_mem_we   = 1'($urandom);
      fwd_mem_rd   = 5'($urandom % 8);
      fwd_mem_data = {$urandom, $urandom};
      fwd_wb_we    = 1'($urandom);
      fwd_wb_rd    = 5'($urandom % 8);
      fwd_wb_data  = {$urandom, $urandom};
      tick();
    end
    sample();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and the 64-bit ALU.
- Latches decoded operands, immediate, PC, destination and a 4-bit ALUOp.
- Resolves operand forwarding from MEM and WB, then drives the ALU A/B/ALUOp inputs.
- Detects load-use hazards and inserts a one-cycle bubble.
- Honours downstream stall and branch flush.

Parameters:
XLEN, 64, datapath width of operands, immediate and PC
RADDR, 5, register address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
rs1_addr, rs2_addr, rd_addr  in  RADDR  decoded register addresses
uses_rs1, uses_rs2  in  1  instruction reads rs1/rs2
rs1_data, rs2_data  in  XLEN  register-file read data
imm, pc  in  XLEN  immediate and instruction PC
alu_src_imm, alu_src_pc  in  1  B=imm / A=pc select
ALUOp_in  in  4  ALU operation code
reg_write_in, mem_read_in, mem_write_in  in  1  control bits
out_ready  in  1  EX/MEM can take the held instruction
flush  in  1  discard held and incoming instruction
fwd_mem_we, fwd_mem_rd, fwd_mem_data  in  1/RADDR/XLEN  MEM-stage result
fwd_wb_we, fwd_wb_rd, fwd_wb_data  in  1/RADDR/XLEN  WB write port
out_valid  out  1  A/B/ALUOp valid
A, B  out  XLEN  ALU operands
ALUOp  out  4  ALU operation
store_data  out  XLEN  forwarded rs2 for stores
rd_out  out  RADDR  destination register
reg_write_out, mem_read_out, mem_write_out  out  1  control bits, qualified by out_valid

Behaviour:
- Reset (async, immediate): out_valid=0, all held fields=0, control bits=0, A=B=store_data=0, ALUOp=4'b0000.
- advance = !out_valid || out_ready.
- hazard = out_valid && mem_read_q && rd_q!=0 && in_valid && ((uses_rs1 && rs1_addr==rd_q) || (uses_rs2 && rs2_addr==rd_q)).
- in_ready = advance && !hazard && !flush (combinational).
- Rising edge, priority order:
  - flush: out_valid<=0, control bits<=0.
  - else advance && in_valid && !hazard: load all fields, out_valid<=1.
  - else advance: bubble, out_valid<=0, control bits<=0.
  - else: hold everything.
- Hazard stalls exactly one cycle: the bubble moves the load downstream, hazard clears, and the instruction is accepted next cycle (given out_ready=1).
- Capture bypass: at load, if fwd_wb_we && fwd_wb_rd==rs1_addr && rs1_addr!=0, latch fwd_wb_data instead of rs1_data. Same rule for rs2.
- Output forwarding (combinational, on held rs1_q/rs2_q):
  - MEM match beats WB match, which beats the held value.
  - Register x0 is never forwarded.
  - Forwarding is re-evaluated every cycle while held.
- A = alu_src_pc ? pc_q : fwd_rs1. B = alu_src_imm ? imm_q : fwd_rs2. store_data = fwd_rs2.
- When out_valid=0: A, B, store_data forced 0; ALUOp 4'b0000; control outputs 0.
- Latency: accepted instruction appears on outputs one cycle after acceptance.
- flush together with a hazard or out_ready=0: flush wins; stage empties next cycle.
- Reset asserted mid-stall: held instruction is lost; in_ready=1 the cycle after reset releases.

Test Plan:
- Reset, then accept rs1_data=10, rs2_data=10, ALUOp_in=4'b0010, rd=3 -> next cycle out_valid=1, A=10, B=10, ALUOp=4'b0010, rd_out=3.
- Held rs1=5 with fwd_mem_we=1, fwd_mem_rd=5, data=30 and fwd_wb_rd=5, data=99 -> A=30. With fwd_mem_we=0 -> A=99. With rs1=0 and both matching x0 -> A=held value.
- Held load to rd=7, incoming add uses rs2=7 -> in_ready=0 one cycle, out_valid=0 next cycle, add accepted the following cycle with B=fwd_mem_data.
- out_ready=0 for 3 cycles with held ALUOp=4'b0001 -> outputs stable, in_ready=0. out_ready=1 -> next instruction loads.
- flush while holding a valid instruction and in_valid=1 -> in_ready=0, next cycle out_valid=0, ALUOp=0, reg_write_out=0.
- Accept with fwd_wb_we=1, fwd_wb_rd=rs1_addr=4, wb_data=64'h3FF, rs1_data=0 -> A=64'h3FF after capture, persisting after WB deasserts.
